// File: rtl/status_sequencer_pkg.sv
// Shared encodings for the status-register sequencer: condition codes,
// FSM states and write-source select.
package status_sequencer_pkg;

  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_C      = 3'd1;
  localparam logic [2:0] COND_NC     = 3'd2;
  localparam logic [2:0] COND_Z      = 3'd3;
  localparam logic [2:0] COND_NZ     = 3'd4;
  localparam logic [2:0] COND_C_NZ   = 3'd5;
  localparam logic [2:0] COND_NC_Z   = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_ALU     = 2'd0,
    SRC_SW      = 2'd1,
    SRC_RESTORE = 2'd2
  } src_t;

endpackage

// File: rtl/status_sequencer_if.sv
// Request/ack, condition and status-register signals of the sequencer.
// slave = sequencer side, master = requesters plus the status register.
interface status_sequencer_if;
  logic       aluReq, aluC, aluZ, aluAck;
  logic       swReq, swC, swZ, swAck;
  logic       saveReq, restoreReq, restoreAck;
  logic       condReq;
  logic [2:0] condCode;
  logic       condValid, condTaken;
  logic       statusC, statusZ;
  logic       notLoad, cOut, zOut;
  logic       shadowValid, busy;

  modport slave (
    input  aluReq, aluC, aluZ, swReq, swC, swZ, saveReq, restoreReq,
           condReq, condCode, statusC, statusZ,
    output aluAck, swAck, restoreAck, condValid, condTaken,
           notLoad, cOut, zOut, shadowValid, busy
  );

  modport master (
    output aluReq, aluC, aluZ, swReq, swC, swZ, saveReq, restoreReq,
           condReq, condCode, statusC, statusZ,
    input  aluAck, swAck, restoreAck, condValid, condTaken,
           notLoad, cOut, zOut, shadowValid, busy
  );
endinterface

// File: rtl/status_sequencer_cond_eval.sv
// Combinational branch-condition evaluator over the carry/zero flags.
// Zero latency; no handshake.
module status_cond_eval
  import status_sequencer_pkg::*;
(
  input  logic [2:0] code,
  input  logic       c,
  input  logic       z,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (code)
      COND_ALWAYS: taken = 1'b1;
      COND_C:      taken = c;
      COND_NC:     taken = ~c;
      COND_Z:      taken = z;
      COND_NZ:     taken = ~z;
      COND_C_NZ:   taken = c & ~z;
      COND_NC_Z:   taken = ~c | z;
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_sequencer.sv
// Arbitrates flag writes (restore > sw > alu), strobes notLoad for HOLD_CYCLES,
// keeps a one-deep shadow and evaluates conditions; losers and conditions wait.
module status_sequencer
  import status_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input logic               clock,
  input logic               notReset,
  status_sequencer_if.slave bus
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  src_t       src, grant_src;
  logic [3:0] hold_cnt;
  logic       c_q, z_q;
  logic       shadow_c, shadow_z, shadow_vld, sv_clear;
  logic       cond_pend, cond_accept, cond_taken_nxt;
  logic       cond_vld_q, cond_taken_q;
  logic [2:0] cond_code_q, cond_code_eff;
  logic       any_req, grant, write_done;

  assign any_req    = bus.aluReq | bus.swReq | bus.restoreReq;
  assign grant      = (state == IDLE) && any_req;
  assign write_done = (state == WRITE) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_src = SRC_ALU;
    if (bus.restoreReq)  grant_src = SRC_RESTORE;
    else if (bus.swReq)  grant_src = SRC_SW;
    case (state)
      IDLE:    if (any_req) state_nxt = WRITE;
      WRITE:   if (hold_cnt == HOLD_LAST) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // sv_clear: a restore only invalidates the shadow if no save landed during it
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      src      <= SRC_ALU;
      hold_cnt <= 4'd0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      sv_clear <= 1'b0;
    end else begin
      hold_cnt <= (state == WRITE) ? hold_cnt + 4'd1 : 4'd0;
      if (grant) begin
        src      <= grant_src;
        sv_clear <= (grant_src == SRC_RESTORE) && !bus.saveReq;
        case (grant_src)
          SRC_RESTORE: {c_q, z_q} <= {shadow_c, shadow_z};
          SRC_SW:      {c_q, z_q} <= {bus.swC, bus.swZ};
          default:     {c_q, z_q} <= {bus.aluC, bus.aluZ};
        endcase
      end else if (bus.saveReq) begin
        sv_clear <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      shadow_c   <= 1'b0;
      shadow_z   <= 1'b0;
      shadow_vld <= 1'b0;
    end else if (bus.saveReq) begin
      {shadow_c, shadow_z} <= (state == WRITE) ? {c_q, z_q} : {bus.statusC, bus.statusZ};
      shadow_vld           <= 1'b1;
    end else if (write_done && sv_clear) begin
      shadow_vld <= 1'b0;
    end
  end

  assign cond_code_eff = bus.condReq ? bus.condCode : cond_code_q;
  assign cond_accept   = (bus.condReq | cond_pend) && (state == IDLE) && !any_req;

  status_cond_eval u_cond_eval (
    .code  (cond_code_eff),
    .c     (bus.statusC),
    .z     (bus.statusZ),
    .taken (cond_taken_nxt)
  );

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      cond_pend    <= 1'b0;
      cond_code_q  <= COND_ALWAYS;
      cond_vld_q   <= 1'b0;
      cond_taken_q <= 1'b0;
    end else if (cond_accept) begin
      cond_pend    <= 1'b0;
      cond_vld_q   <= 1'b1;
      cond_taken_q <= cond_taken_nxt;
    end else begin
      cond_vld_q <= 1'b0;
      if (bus.condReq) begin
        cond_pend   <= 1'b1;
        cond_code_q <= bus.condCode;
      end
    end
  end

  assign bus.notLoad     = (state != WRITE);
  assign bus.cOut        = c_q;
  assign bus.zOut        = z_q;
  assign bus.aluAck      = (state == ACK) && (src == SRC_ALU);
  assign bus.swAck       = (state == ACK) && (src == SRC_SW);
  assign bus.restoreAck  = (state == ACK) && (src == SRC_RESTORE);
  assign bus.condValid   = cond_vld_q;
  assign bus.condTaken   = cond_taken_q;
  assign bus.shadowValid = shadow_vld;
  assign bus.busy        = (state != IDLE);

endmodule
